// File: rtl/conv_arbiter.sv
// Round-robin arbiter feeding one shared 64-to-8 converter: grants one requester's
// word, presents it until accepted, then waits for eight byte strobes or a timeout.
module conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [64*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ack,
  output logic                 valid_in,
  output logic [63:0]          data_in,
  input  logic                 conv_ready,
  input  logic                 byte_strobe,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [IDW-1:0]    ptr_reg, ptr_next;
  logic [IDW-1:0]    grant_reg, grant_next;
  logic [63:0]       data_reg, data_next;
  logic [3:0]        byte_cnt_reg, byte_cnt_next;
  logic [15:0]       timer_reg, timer_next;
  logic [N_REQ-1:0]  ack_reg, ack_next;

  logic [63:0]       req_word [N_REQ];
  logic [IDW-1:0]    cand_idx [N_REQ];
  logic [N_REQ-1:0]  cand_hit;
  logic [IDW-1:0]    sel_idx;
  logic              sel_any;
  logic              last_strobe;
  logic              timeout_now;

  // Candidate gi is the requester gi+1 places above the pointer, wrapped modulo N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [4:0] sum;
    assign req_word[gi] = req_data[64*gi +: 64];
    assign sum          = 5'(ptr_reg) + 5'(gi + 1);
    assign cand_idx[gi] = (sum >= 5'(N_REQ)) ? IDW'(sum - 5'(N_REQ)) : IDW'(sum);
    assign cand_hit[gi] = req_valid[cand_idx[gi]];
  end

  // Lowest-offset candidate wins, so iterate downward and let the last hit stick.
  always_comb begin
    sel_any = |cand_hit;
    sel_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        sel_idx = cand_idx[k];
      end
    end
  end

  // A completing eighth strobe takes precedence over a coincident timeout.
  assign last_strobe = (state_reg == DRAIN) && byte_strobe && (byte_cnt_reg == 4'd7);
  assign timeout_now = (state_reg == DRAIN) && !last_strobe &&
                       (timer_reg == 16'(TIMEOUT - 1));

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_next    = grant_reg;
    data_next     = data_reg;
    byte_cnt_next = byte_cnt_reg;
    timer_next    = timer_reg;
    ack_next      = '0;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          grant_next = sel_idx;
          data_next  = req_word[sel_idx];
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (conv_ready) begin
          ack_next[grant_reg] = 1'b1;
          byte_cnt_next       = '0;
          timer_next          = '0;
          state_next          = DRAIN;
        end
      end
      DRAIN: begin
        timer_next = timer_reg + 16'd1;
        if (byte_strobe) begin
          byte_cnt_next = byte_cnt_reg + 4'd1;
        end
        if (last_strobe || timeout_now) begin
          ptr_next   = grant_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= IDW'(N_REQ - 1);
      grant_reg    <= '0;
      data_reg     <= '0;
      byte_cnt_reg <= '0;
      timer_reg    <= '0;
      ack_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      data_reg     <= data_next;
      byte_cnt_reg <= byte_cnt_next;
      timer_reg    <= timer_next;
      ack_reg      <= ack_next;
    end
  end

  assign req_ack     = ack_reg;
  assign valid_in    = (state_reg == LAUNCH);
  assign data_in     = data_reg;
  assign grant_id    = grant_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_now;

endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter: single transfer, round robin, backpressure,
// timeout, strobe/timeout coincidence and mid-transfer reset.
module tb_conv_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [64*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           valid_in;
  logic [63:0]    data_in;
  logic           conv_ready;
  logic           byte_strobe;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  conv_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .conv_ready  (conv_ready),
    .byte_strobe (byte_strobe),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobes(input int n);
    byte_strobe = 1'b1;
    repeat (n) cyc();
    byte_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp [5];
    rr_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = '0; req_data = '0; conv_ready = 1'b0; byte_strobe = 1'b0;
    #1;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_valid", 64'(valid_in), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_data",  data_in, 64'd0);
    chk("rst_ack",   64'(req_ack), 64'd0);
    chk("rst_terr",  64'(timeout_err), 64'd0);
    cyc(); cyc();
    rst = 1'b0;

    // Single request; strobes held through IDLE and LAUNCH must be ignored.
    req_valid = 4'b0100;
    req_data[64*2 +: 64] = 64'h0123_4567_89AB_CDEF;
    conv_ready = 1'b1;
    byte_strobe = 1'b1;
    cyc();
    chk("t1_valid", 64'(valid_in), 64'd1);
    chk("t1_data",  data_in, 64'h0123_4567_89AB_CDEF);
    chk("t1_grant", 64'(grant_id), 64'd2);
    chk("t1_noack", 64'(req_ack), 64'd0);
    cyc();
    chk("t1_ack",   64'(req_ack), 64'b0100);
    chk("t1_vdrop", 64'(valid_in), 64'd0);
    req_valid = 4'b0000;
    cyc();
    chk("t1_ack1c", 64'(req_ack), 64'd0);
    repeat (6) cyc();
    chk("t1_busy7", 64'(busy), 64'd1);
    cyc();
    byte_strobe = 1'b0;
    chk("t1_idle",  64'(busy), 64'd0);

    // Round robin from a fresh pointer.
    rst = 1'b1; #1; cyc(); rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) req_data[64*k +: 64] = 64'hA000_0000_0000_0000 | 64'(k);
    conv_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_grant", 64'(grant_id), 64'(rr_exp[k]));
      chk("rr_data",  data_in, 64'hA000_0000_0000_0000 | 64'(rr_exp[k]));
      cyc();
      chk("rr_ack",   64'(req_ack), 64'(4'b0001 << rr_exp[k]));
      strobes(8);
      chk("rr_gap",   64'(valid_in), 64'd0);
    end
    req_valid = 4'b0000;

    // Backpressure: 20 stalled LAUNCH cycles, then handshake.
    req_valid = 4'b0010;
    req_data[64*1 +: 64] = 64'hDEAD_BEEF_CAFE_F00D;
    conv_ready = 1'b0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 64'(valid_in), 64'd1);
      chk("bp_data",  data_in, 64'hDEAD_BEEF_CAFE_F00D);
      chk("bp_noack", 64'(req_ack), 64'd0);
      cyc();
    end
    chk("bp_grant", 64'(grant_id), 64'd1);
    conv_ready = 1'b1;
    req_valid = 4'b0000;
    req_data[64*1 +: 64] = 64'h1111_2222_3333_4444;
    cyc();
    chk("bp_ack",   64'(req_ack), 64'b0010);
    strobes(8);
    chk("bp_idle",  64'(busy), 64'd0);

    // Timeout after only 5 strobes; pointer still advances.
    req_valid = 4'b1111;
    cyc();
    chk("to_grant", 64'(grant_id), 64'd2);
    cyc();
    strobes(5);
    for (int i = 0; i < 10; i++) begin
      chk("to_early", 64'(timeout_err), 64'd0);
      cyc();
    end
    chk("to_pulse", 64'(timeout_err), 64'd1);
    chk("to_busy",  64'(busy), 64'd1);
    cyc();
    chk("to_idle",  64'(busy), 64'd0);
    chk("to_clear", 64'(timeout_err), 64'd0);
    chk("to_noack", 64'(req_ack), 64'd0);
    cyc();
    chk("to_next",  64'(grant_id), 64'd3);
    req_valid = 4'b0000;
    cyc();
    strobes(8);

    // Eighth strobe lands exactly on the timeout cycle.
    req_valid = 4'b0001;
    cyc();
    chk("co_grant", 64'(grant_id), 64'd0);
    req_valid = 4'b0000;
    cyc();
    repeat (8) cyc();
    byte_strobe = 1'b1;
    repeat (7) cyc();
    chk("co_noerr", 64'(timeout_err), 64'd0);
    cyc();
    byte_strobe = 1'b0;
    chk("co_idle",  64'(busy), 64'd0);
    chk("co_noerr2", 64'(timeout_err), 64'd0);

    // Reset in DRAIN after 3 strobes.
    req_valid = 4'b0100;
    cyc();
    chk("mr_grant", 64'(grant_id), 64'd2);
    req_valid = 4'b0000;
    cyc();
    strobes(3);
    chk("mr_busy",  64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("mr_busy0", 64'(busy), 64'd0);
    chk("mr_valid", 64'(valid_in), 64'd0);
    chk("mr_gid",   64'(grant_id), 64'd0);
    chk("mr_data",  data_in, 64'd0);
    chk("mr_ack",   64'(req_ack), 64'd0);
    chk("mr_terr",  64'(timeout_err), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("mr_regrant", 64'(grant_id), 64'd0);
    chk("mr_revalid", 64'(valid_in), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
